iter_shifter: RTL
=================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two >= 8.
REQ-002 Parameter STEP, default 1, maximum bits shifted per clock; SHALL be a power of two in 1..WIDTH/2.
REQ-003 Derived localparam SHAMT_W = log2(WIDTH), shift-amount width.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request; sampled only in IDLE or DONE.
REQ-007 mode  in  3  0=LSL, 1=LSR, 2=ASR, 3=ROL, 4=ROR, 5..7 reserved.
REQ-008 operand  in  WIDTH  value to shift.
REQ-009 shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
REQ-010 busy  out  1  high while in SHIFT.
REQ-011 done  out  1  one-cycle pulse, result valid.
REQ-012 result  out  WIDTH  shifted value; held until next accepted start.
REQ-013 carry_out  out  1  last bit shifted out (rotates: last bit wrapped).
REQ-014 zero  out  1  result == 0; same timing as result.

Function
REQ-015 FSM states IDLE, SHIFT, DONE; IDLE on reset.
REQ-016 IDLE/DONE with start=1: latch operand, mode, shamt; clear carry; go SHIFT if effective amount > 0, else DONE.
REQ-017 Reserved modes SHALL be treated as effective amount 0: result = operand, carry_out = 0.
REQ-018 Each SHIFT edge shifts by k = min(STEP, remaining), decrements remaining by k; edge where remaining becomes 0 moves to DONE.
REQ-019 done SHALL be high for exactly the cycle after edge E0 + ceil(shamt/STEP), E0 = start-sampling edge; shamt=0 gives done in cycle after E0.
REQ-020 DONE without start returns to IDLE next edge; DONE with start accepts back-to-back (no idle bubble).
REQ-021 start while in SHIFT SHALL be ignored; input changes during SHIFT SHALL not affect the operation.
REQ-022 LSL/LSR fill zeros; ASR fills with latched operand MSB; ROL/ROR lose no bits.
REQ-023 carry_out: LSL bit WIDTH-shamt of operand; LSR/ASR bit shamt-1; ROL result bit 0; ROR result bit WIDTH-1; 0 when amount 0.
REQ-024 result/carry_out/zero SHALL change only on the edge entering DONE; intermediate values not visible on result.
REQ-025 Final result SHALL be independent of STEP; only latency differs.

Reset
REQ-026 reset SHALL dominate start on the same edge.
REQ-027 On reset: state IDLE, busy=0, done=0, result=0, carry_out=0, zero=1, remaining=0.
REQ-028 Reset mid-SHIFT SHALL discard the operation; no done pulse follows.

Structure
REQ-029 Package shift_pkg SHALL hold mode encodings and the FSM state enum, shared with the processor ALU decode.
REQ-030 One combinational sub-module shift_step (one k-bit step given mode, returns value and outgoing bit) SHALL be instantiated once.

Verification
REQ-031 WIDTH=32, STEP=1: LSL 0xA081BD73 by 10 -> result 0x06F5CC00, carry 0, done 10 cycles after start.
REQ-032 LSR 0x06F5CC00 by 1 -> 0x037AE600, carry 0; ASR 0xDEB98000 by 4 -> 0xFDEB9800, carry 0.
REQ-033 ROR 0xA081BD73 by 4 -> 0x3A081BD7, carry 0; ROL 0x80000001 by 1 -> 0x00000003, carry 1.
REQ-034 STEP=4 repeat of REQ-031..033 -> identical results; LSL by 10 done 3 cycles after start; shamt 0 -> result=operand, done next cycle, zero per value.
REQ-035 start pulsed during SHIFT and on DONE cycle: first ignored, second accepted back-to-back; done pulses exactly once per accepted op.
REQ-036 reset asserted mid-SHIFT (and coincident with start) -> outputs at reset values next cycle, no done pulse, FSM IDLE.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared shifter encodings: mode decode values and the iterative FSM state type.
// Also used by the processor ALU decode.
package shift_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        ModeLsl = 3'd0,
        ModeLsr = 3'd1,
        ModeAsr = 3'd2,
        ModeRol = 3'd3,
        ModeRor = 3'd4
    } shift_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    function automatic logic mode_reserved(input logic [MODE_W-1:0] mode);
        return mode > ModeRor;
    endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle for iter_shifter: operation inputs plus status and result outputs.
interface iter_shifter_if #(
    parameter int unsigned WIDTH = 32
) ();
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic               start;
    logic [2:0]         mode;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               carry_out;
    logic               zero;

    modport master (
        output start, mode, operand, shamt,
        input  busy, done, result, carry_out, zero
    );

    modport slave (
        input  start, mode, operand, shamt,
        output busy, done, result, carry_out, zero
    );
endinterface

// File: rtl/shift_step.sv
// One combinational shift/rotate step by a small amount; bit_out is the last bit moved out
// (for rotates, the last bit wrapped around).
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   value_in,
    input  logic [SHAMT_W-1:0] amount,
    output logic [WIDTH-1:0]   value_out,
    output logic               bit_out
);
    localparam logic [SHAMT_W:0] WidthL = (SHAMT_W + 1)'(WIDTH);

    logic [SHAMT_W:0] back;
    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] ror;

    // The last bit leaving on the left lands in rol[0]; leaving on the right lands in ror[MSB].
    always_comb begin
        back      = WidthL - {1'b0, amount};
        rol       = (value_in << amount) | (value_in >> back);
        ror       = (value_in >> amount) | (value_in << back);
        value_out = value_in;
        bit_out   = 1'b0;
        case (mode)
            ModeLsl: begin
                value_out = value_in << amount;
                bit_out   = rol[0];
            end
            ModeLsr: begin
                value_out = value_in >> amount;
                bit_out   = ror[WIDTH-1];
            end
            ModeAsr: begin
                value_out = $signed(value_in) >>> amount;
                bit_out   = ror[WIDTH-1];
            end
            ModeRol: begin
                value_out = rol;
                bit_out   = rol[0];
            end
            ModeRor: begin
                value_out = ror;
                bit_out   = ror[WIDTH-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle barrel-shifter replacement: shifts up to STEP bits per clock and publishes
// result/carry/zero only when the operation completes.
module iter_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input logic            clk,
    input logic            reset,
    iter_shifter_if.slave  bus
);
    localparam int unsigned      SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] StepL = SHAMT_W'(STEP);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2:0]         mode_q, mode_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   step_value;
    logic               step_bit;

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .mode      (mode_q),
        .value_in  (work_q),
        .amount    (k),
        .value_out (step_value),
        .bit_out   (step_bit)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        mode_d   = mode_q;
        rem_d    = rem_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        k        = (rem_q < StepL) ? rem_q : StepL;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    work_d = bus.operand;
                    mode_d = bus.mode;
                    // Zero or reserved shifts complete immediately with the operand unchanged.
                    if (mode_reserved(bus.mode) || bus.shamt == '0) begin
                        rem_d    = '0;
                        state_d  = StDone;
                        result_d = bus.operand;
                        carry_d  = 1'b0;
                        zero_d   = (bus.operand == '0);
                    end else begin
                        rem_d   = bus.shamt;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d = step_value;
                rem_d  = rem_q - k;
                if (rem_d == '0) begin
                    state_d  = StDone;
                    result_d = step_value;
                    carry_d  = step_bit;
                    zero_d   = (step_value == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            work_q   <= '0;
            mode_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            mode_q   <= mode_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy      = (state_q == StShift);
    assign bus.done      = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;

endmodule
